// File: rtl/i2c_pkg.sv
// i2c_pkg: constants and state encodings shared by the I2C master and
// target engines.
package i2c_pkg;

  // Direction bit carried in the LSB of the address byte
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

  // Level on SDA during the 9th clock of a byte
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Target engine states; the *_ACK states cover the 9th SCL clock of a byte
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_A_ACK  = 4'd2,
    ST_PTR    = 4'd3,
    ST_P_ACK  = 4'd4,
    ST_WR     = 4'd5,
    ST_W_ACK  = 4'd6,
    ST_RD     = 4'd7,
    ST_M_ACK  = 4'd8,
    ST_IGNORE = 4'd9
  } i2c_state_e;

  // True when the 7-bit address field of a received address byte matches
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return (addr_byte[7:1] == dev);
  endfunction

endpackage

// File: rtl/i2c_target_regport_if.sv
// Byte-wide register port between the I2C target engine (master side)
// and the register file it reads and writes (slave side).
interface i2c_target_regport_if;

  logic [7:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wr,
    output reg_wdata,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wr,
    input  reg_wdata,
    input  reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizer, optional glitch filter and registered
// edge detector for one I2C line. The filter is built only when
// I2C_GLITCH_FILTER_EN is defined; it then needs FILT_LEN consecutive equal
// synchronized samples before the level follows. Idle level is high.
module i2c_line_sync #(
  parameter int unsigned FILT_LEN = 32'd3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic level_q;
  logic rise_q;
  logic fall_q;
  logic clean_s;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = (FILT_LEN > 32'd1) ? $clog2(FILT_LEN) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 32'd1);

  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive samples that disagree with the filtered level
  always_comb begin
    filt_d = filt_q;
    cnt_d  = {CNT_W{1'b0}};
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync2_q;
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Filter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign clean_s = filt_q;
`else
  assign clean_s = sync2_q;
`endif

  // Registered level plus one-cycle rise/fall pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= clean_s;
      rise_q  <= clean_s & ~level_q;
      fall_q  <= ~clean_s & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regport.sv
// i2c_target_regport: I2C target answering DEV_ADDR with a byte-wide
// register port and an auto-incrementing, wrapping register pointer.
// Write: addr+W, pointer byte, data bytes. Read: addr+R, data bytes until
// the host NACKs. SCL is never driven. Defining I2C_GLITCH_FILTER_EN adds a
// FILT_LEN-deep glitch filter on both lines.
module i2c_target_regport
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h48,
  parameter int unsigned FILT_LEN = 32'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic                 busy,
  i2c_target_regport_if.master regs
);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;

  i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
    .clk(clk), .reset(reset), .pin_i(scl_i),
    .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
  );

  i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
    .clk(clk), .reset(reset), .pin_i(sda_i),
    .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
  );

  // Both lines share one pipeline depth, so SCL level lines up with SDA edges
  assign start_s = sda_fall_s & scl_lvl_s;
  assign stop_s  = sda_rise_s & scl_lvl_s;

  // Next-state logic: bus conditions first (START beats STOP), then per-state bit handling
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    // Pointer steps the cycle after each register access; 8'hFF wraps to 8'h00
    if (wr_q || rd_q) begin
      ptr_d = ptr_q + 8'd1;
    end else begin
      ptr_d = ptr_q;
    end

    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise_s && (bit_cnt_q != 4'd8)) begin
            shift_d   = {shift_q[6:0], sda_lvl_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (addr_match(shift_q, DEV_ADDR)) begin
                state_d  = ST_A_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d  = ST_IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d    = shift_q;
              state_d  = ST_P_ACK;
              sda_oe_d = 1'b1;
            end else begin
              wr_d     = 1'b1;
              wdata_d  = shift_q;
              state_d  = ST_W_ACK;
              sda_oe_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_A_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (rw_q == I2C_RD) begin
              // sda_oe stays asserted one more clk until the read byte loads
              state_d = ST_RD;
              rd_d    = 1'b1;
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = ST_A_ACK;
          end
        end
        ST_P_ACK, ST_W_ACK: begin
          if (scl_fall_s) begin
            state_d   = ST_WR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_RD: begin
          if (rd_q) begin
            // reg_rdata is valid in the reg_rd cycle: load it and present the MSB
            shift_d   = regs.reg_rdata;
            sda_oe_d  = ~regs.reg_rdata[7];
            bit_cnt_d = 4'd0;
          end else if (scl_fall_s) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = ST_M_ACK;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_RD;
          end
        end
        ST_M_ACK: begin
          if (scl_rise_s && (sda_lvl_s == I2C_NACK)) begin
            state_d = ST_IGNORE;
          end else if (scl_fall_s) begin
            state_d = ST_RD;
            rd_d    = 1'b1;
          end else begin
            state_d = ST_M_ACK;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      wdata_q   <= 8'h00;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  assign sda_oe         = sda_oe_q;
  assign busy           = busy_q;
  assign regs.reg_addr  = ptr_q;
  assign regs.reg_wr    = wr_q;
  assign regs.reg_wdata = wdata_q;
  assign regs.reg_rd    = rd_q;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Bench for i2c_target_regport: an I2C host model drives the pins, a
// register-file model answers reads, and a scoreboard of expected register
// accesses is checked against the reg_wr / reg_rd strobes.
module tb_i2c_target_regport;
  import i2c_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_host = 1'b1;
  logic sda_host = 1'b1;
  logic scl_i, sda_i, sda_oe, busy;
  logic [7:0] mem [256];

  wr_t        exp_wr_q [$];
  logic [7:0] exp_rd_q [$];
  wr_t        mon_e;
  logic [7:0] mon_a;
  int         n_checks = 0;
  int         n_pass = 0;

  i2c_target_regport_if rf ();

  assign rf.reg_rdata = mem[rf.reg_addr];
  assign scl_i = scl_host;
  assign sda_i = sda_host & ~sda_oe;

  i2c_target_regport #(.DEV_ADDR(7'h48), .FILT_LEN(32'd3)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .busy(busy), .regs(rf)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_host = 1'b1; tick();
    scl_host = 1'b1; tick();
    sda_host = 1'b0; tick();
    scl_host = 1'b0; tick();
  endtask

  task automatic i2c_stop();
    sda_host = 1'b0; tick();
    scl_host = 1'b1; tick();
    sda_host = 1'b1; tick(); tick();
  endtask

  // Eight data clocks; spike_bit selects a bit whose high phase gets a 2-clk SCL low pulse
  task automatic send_bits(input logic [7:0] b, input int spike_bit);
    for (int i = 7; i >= 0; i--) begin
      sda_host = b[i]; tick();
      scl_host = 1'b1;
      if (i == spike_bit) begin
        repeat (Q - 1) @(negedge clk);
        scl_host = 1'b0;
        repeat (2) @(negedge clk);
        scl_host = 1'b1;
        repeat (Q - 1) @(negedge clk);
      end else begin
        tick(); tick();
      end
      scl_host = 1'b0; tick();
    end
  endtask

  task automatic ack_clk(output logic a);
    sda_host = 1'b1; tick();
    scl_host = 1'b1; tick();
    a = sda_i;       tick();
    scl_host = 1'b0; tick();
  endtask

  task automatic write_byte(input logic [7:0] b, input int spike_bit, output logic a);
    send_bits(b, spike_bit);
    ack_clk(a);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      sda_host = 1'b1; tick();
      scl_host = 1'b1; tick();
      b[i] = sda_i;    tick();
      scl_host = 1'b0; tick();
    end
    sda_host = nack; tick();
    scl_host = 1'b1; tick(); tick();
    scl_host = 1'b0; tick();
    sda_host = 1'b1;
  endtask

  // Scoreboard: every strobe pops and checks the oldest expected access
  always @(negedge clk) begin
    if (rf.reg_wr || rf.reg_rd) begin
      check_val("wr_rd_excl", {31'd0, rf.reg_wr & rf.reg_rd}, 32'd0);
    end
    if (rf.reg_wr) begin
      if (exp_wr_q.size() == 0) begin
        check_val("wr_unexpected", {31'd0, rf.reg_wr}, 32'd0);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check_val("wr_addr", {24'd0, rf.reg_addr}, {24'd0, mon_e.a});
        check_val("wr_data", {24'd0, rf.reg_wdata}, {24'd0, mon_e.d});
      end
    end
    if (rf.reg_rd) begin
      if (exp_rd_q.size() == 0) begin
        check_val("rd_unexpected", {31'd0, rf.reg_rd}, 32'd0);
      end else begin
        mon_a = exp_rd_q.pop_front();
        check_val("rd_addr", {24'd0, rf.reg_addr}, {24'd0, mon_a});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] spike_d;
    logic       spike_a;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[3] = 8'hA5;
    mem[4] = 8'h5A;

    // Reset state
    repeat (4) @(negedge clk);
    check_val("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ptr", {24'd0, rf.reg_addr}, 32'd0);
    check_val("rst_wr", {31'd0, rf.reg_wr}, 32'd0);
    check_val("rst_rd", {31'd0, rf.reg_rd}, 32'd0);
    check_val("rst_wdata", {24'd0, rf.reg_wdata}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: pointer write and two data writes
    i2c_start();
    write_byte(8'h90, -1, a); check_val("t1_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h1D, -1, a); check_val("t1_ptr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    exp_wr_q.push_back('{a: 8'h1D, d: 8'h00});
    exp_wr_q.push_back('{a: 8'h1E, d: 8'h11});
    write_byte(8'h00, -1, a); check_val("t1_d0_ack", {31'd0, a}, {31'd0, I2C_ACK});
    write_byte(8'h11, -1, a); check_val("t1_d1_ack", {31'd0, a}, {31'd0, I2C_ACK});
    i2c_stop();
    check_val("t1_busy_stop", {31'd0, busy}, 32'd0);
    check_val("t1_ptr_end", {24'd0, rf.reg_addr}, 32'h1F);

    // 2: foreign address is ignored
    i2c_start();
    write_byte(8'h92, -1, a); check_val("t2_addr_nack", {31'd0, a}, {31'd0, I2C_NACK});
    check_val("t2_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h55, -1, a); check_val("t2_data_nack", {31'd0, a}, {31'd0, I2C_NACK});
    i2c_stop();
    check_val("t2_ptr", {24'd0, rf.reg_addr}, 32'h1F);

    // 3: set pointer, repeated START, read two bytes
    i2c_start();
    write_byte(8'h90, -1, a); check_val("t3_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    write_byte(8'h03, -1, a); check_val("t3_ptr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    i2c_start();
    exp_rd_q.push_back(8'h03);
    exp_rd_q.push_back(8'h04);
    write_byte(8'h91, -1, a); check_val("t3_raddr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    read_byte(b, I2C_ACK);    check_val("t3_rd0", {24'd0, b}, 32'hA5);
    read_byte(b, I2C_NACK);   check_val("t3_rd1", {24'd0, b}, 32'h5A);
    check_val("t3_released", {31'd0, sda_oe}, 32'd0);
    check_val("t3_busy", {31'd0, busy}, 32'd1);
    i2c_stop();
    check_val("t3_ptr_end", {24'd0, rf.reg_addr}, 32'h05);
    check_val("t3_busy_stop", {31'd0, busy}, 32'd0);

    // 4: pointer wrap
    i2c_start();
    write_byte(8'h90, -1, a); check_val("t4_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    write_byte(8'hFF, -1, a); check_val("t4_ptr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    exp_wr_q.push_back('{a: 8'hFF, d: 8'h12});
    exp_wr_q.push_back('{a: 8'h00, d: 8'h34});
    write_byte(8'h12, -1, a); check_val("t4_d0_ack", {31'd0, a}, {31'd0, I2C_ACK});
    write_byte(8'h34, -1, a); check_val("t4_d1_ack", {31'd0, a}, {31'd0, I2C_ACK});
    i2c_stop();
    check_val("t4_ptr_end", {24'd0, rf.reg_addr}, 32'h01);

    // 5: reset while the address ACK is being driven
    i2c_start();
    send_bits(8'h90, -1);
    check_val("t5_ack_drv", {31'd0, sda_oe}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("t5_rst_sda", {31'd0, sda_oe}, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_val("t5_rst_ptr", {24'd0, rf.reg_addr}, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    i2c_start();
    write_byte(8'h90, -1, a); check_val("t5_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    write_byte(8'h40, -1, a); check_val("t5_ptr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    exp_wr_q.push_back('{a: 8'h40, d: 8'h77});
    write_byte(8'h77, -1, a); check_val("t5_d_ack", {31'd0, a}, {31'd0, I2C_ACK});
    i2c_stop();
    check_val("t5_ptr_end", {24'd0, rf.reg_addr}, 32'h41);

    // 6: 2-clk SCL low spike during the high phase of bit 4 of a data byte
`ifdef I2C_GLITCH_FILTER_EN
    spike_d = 8'hC3;
    spike_a = I2C_ACK;
`else
    spike_d = 8'hC1;
    spike_a = I2C_NACK;
`endif
    i2c_start();
    write_byte(8'h90, -1, a); check_val("t6_addr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    write_byte(8'h50, -1, a); check_val("t6_ptr_ack", {31'd0, a}, {31'd0, I2C_ACK});
    exp_wr_q.push_back('{a: 8'h50, d: spike_d});
    write_byte(8'hC3, 4, a);  check_val("t6_d_ack", {31'd0, a}, {31'd0, spike_a});
    i2c_stop();
    check_val("t6_ptr_end", {24'd0, rf.reg_addr}, 32'h51);

    repeat (10) @(negedge clk);
    check_val("wr_pending", exp_wr_q.size(), 32'd0);
    check_val("rd_pending", exp_rd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
